// File: rtl/alu_mult_seq_if.sv
// Bundle between the pipeline control, the sequential multiplier and the combinational ALU.
// The slave modport is the multiplier's view; the master modport is the surrounding environment.
interface alu_mult_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             signed_op;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] product_hi;
  logic [WIDTH-1:0] product_lo;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [4:0]       alu_op;
  logic [WIDTH-1:0] alu_result;
  logic             alu_carryout;

  modport slave (
    input  start, a, b, signed_op, alu_result, alu_carryout,
    output busy, done, product_hi, product_lo, alu_a, alu_b, alu_op
  );

  modport master (
    output start, a, b, signed_op, alu_result, alu_carryout,
    input  busy, done, product_hi, product_lo, alu_a, alu_b, alu_op
  );
endinterface

// File: rtl/alu_mult_seq.sv
// Shift-add 32x32->64 multiplier driving an external ALU, one add per clock; done after 33 cycles
// (34 with a signed negative result); start is ignored while busy. MULT_SIGNED_EN adds signed support.
module alu_mult_seq #(
  parameter int WIDTH      = 32,
  parameter int ITER_CNT_W = 6
) (
  input  logic         clk,
  input  logic         reset,
  alu_mult_seq_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  localparam logic [WIDTH-1:0]      ONE_W  = WIDTH'(1);
  localparam logic [2*WIDTH-1:0]    ONE_2W = (2*WIDTH)'(1);
  localparam logic [ITER_CNT_W-1:0] LAST   = ITER_CNT_W'(WIDTH - 1);

  state_t                state, state_nxt;
  logic [WIDTH-1:0]      mcand, mcand_nxt;
  logic [WIDTH-1:0]      hi, hi_nxt;
  logic [WIDTH-1:0]      lo, lo_nxt;
  logic [ITER_CNT_W-1:0] cnt, cnt_nxt;
  logic                  neg_pending, neg_nxt;
  logic [2*WIDTH-1:0]    prod;
  logic                  prod_load;
  logic [WIDTH-1:0]      a_load, b_load;
  logic                  neg_load;

`ifdef MULT_SIGNED_EN
  // Signed operands are reduced to magnitudes; the sign is reapplied in FIX.
  always_comb begin
    a_load   = (bus.signed_op && bus.a[WIDTH-1]) ? (~bus.a + ONE_W) : bus.a;
    b_load   = (bus.signed_op && bus.b[WIDTH-1]) ? (~bus.b + ONE_W) : bus.b;
    neg_load = bus.signed_op && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
  end
`else
  logic unused_signed_op;
  assign unused_signed_op = bus.signed_op;
  assign a_load   = bus.a;
  assign b_load   = bus.b;
  assign neg_load = 1'b0;
`endif

  assign bus.alu_op     = 5'b00010;
  assign bus.alu_a      = hi;
  assign bus.alu_b      = lo[0] ? mcand : '0;
  assign bus.busy       = (state != IDLE);
  assign bus.done       = (state == DONE);
  assign bus.product_hi = prod[2*WIDTH-1:WIDTH];
  assign bus.product_lo = prod[WIDTH-1:0];

  always_comb begin
    state_nxt = state;
    mcand_nxt = mcand;
    hi_nxt    = hi;
    lo_nxt    = lo;
    cnt_nxt   = cnt;
    neg_nxt   = neg_pending;
    case (state)
      IDLE: begin
        if (bus.start) begin
          mcand_nxt = a_load;
          hi_nxt    = '0;
          lo_nxt    = b_load;
          cnt_nxt   = '0;
          neg_nxt   = neg_load;
          state_nxt = RUN;
        end
      end
      RUN: begin
        // The 33-bit ALU sum shifts right one place into the {hi, lo} product register.
        {hi_nxt, lo_nxt} = {bus.alu_carryout, bus.alu_result, lo[WIDTH-1:1]};
        cnt_nxt = cnt + ITER_CNT_W'(1);
        if (cnt == LAST) begin
          state_nxt = neg_pending ? FIX : DONE;
        end
      end
      FIX: begin
`ifdef MULT_SIGNED_EN
        {hi_nxt, lo_nxt} = ~{hi, lo} + ONE_2W;
`endif
        state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // The product register loads on entry to DONE so it is already valid while done is high.
  assign prod_load = (state_nxt == DONE) && (state != DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      mcand       <= '0;
      hi          <= '0;
      lo          <= '0;
      cnt         <= '0;
      neg_pending <= 1'b0;
      prod        <= '0;
    end else begin
      state       <= state_nxt;
      mcand       <= mcand_nxt;
      hi          <= hi_nxt;
      lo          <= lo_nxt;
      cnt         <= cnt_nxt;
      neg_pending <= neg_nxt;
      if (prod_load) begin
        prod <= {hi_nxt, lo_nxt};
      end
    end
  end
endmodule

// File: doc/alu_mult_seq.md
Name: alu_mult_seq

Overview:
Multi-cycle 32x32 -> 64-bit shift-add multiplier for the DLX execute stage. It acts as the initiator toward the combinational ALU: it drives the ALU's A/B/Op inputs one iteration per clock and consumes Result and Carryout. It accepts one operation at a time through a start/busy/done handshake from the pipeline control.

Parameters:
WIDTH, 32, operand width; product is 2*WIDTH. Only 32 is verified.
ITER_CNT_W, 6, iteration counter width; must hold the value WIDTH.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  launch request; sampled only in IDLE
a  input  32  multiplicand
b  input  32  multiplier
signed_op  input  1  1 = two's-complement operands; honoured only with MULT_SIGNED_EN
busy  output  1  high from the cycle after accepted start until done
done  output  1  one-cycle pulse when product is valid
product_hi  output  32  upper product word
product_lo  output  32  lower product word
alu_a  output  32  to ALU A: accumulator (hi word)
alu_b  output  32  to ALU B: multiplicand if current multiplier LSB = 1, else 0
alu_op  output  5  to ALU Op: constant 5'b00010 (add)
alu_result  input  32  from ALU Result
alu_carryout  input  1  from ALU Carryout

Behaviour:
- Reset is asynchronous and active-high, with a single clock domain. During reset: state = IDLE; busy = 0, done = 0; product_hi/lo = 0; iteration counter = 0; internal registers = 0.
- alu_op is always 5'b00010. alu_a and alu_b are combinational from the internal registers.
- States are IDLE, RUN, FIX, DONE.
- IDLE:
  - When start = 1: load mcand <- a, hi <- 0, lo <- b, cnt <- 0, then go to RUN.
  - start = 0: stay in IDLE; product outputs hold their last value.
- RUN, once per cycle:
  - {hi, lo} <- {alu_carryout, alu_result, lo[31:1]}, i.e. the 33-bit sum is shifted right one bit into the 64-bit register.
  - cnt <- cnt + 1.
  - When cnt = 31 in the current cycle: go to FIX if a negation is pending, else go to DONE.
- FIX (only with MULT_SIGNED_EN): {hi, lo} <- two's-complement negation of the 64-bit value, using an internal adder (not the ALU). Go to DONE.
- DONE:
  - product_hi/lo <- {hi, lo}; done = 1 for exactly this cycle; go to IDLE.
  - Products are registered and held until the next DONE.
- busy = 1 in RUN, FIX and DONE; otherwise 0.
- Latency, counted from the start-sampling edge to the first cycle with done = 1:
  - 33 cycles unsigned.
  - 34 cycles signed with a negative result.
- start while busy = 1 is ignored. It is not queued and not an error.
- start in the same cycle that done = 1 is ignored, because the FSM is still in DONE. A new op is accepted the next cycle.
- Operands a/b are sampled only at acceptance and may change freely afterwards.
- Reset asserted mid-operation aborts immediately:
  - All state returns to reset values, and no done pulse is issued.
  - After release, the block is idle and accepts start on the first clock.
- Boundary values:
  - Zero operand gives product 0, with full latency; there is no early termination.
  - 0xFFFFFFFF x 0xFFFFFFFF must not lose the carry; alu_carryout feeds hi bit 31.

Optional Feature:
MULT_SIGNED_EN
- Defined, and signed_op = 1 at acceptance:
  - Operands are replaced by their magnitudes at load (internal negation of a[31]/b[31] operands).
  - neg_pending <- a[31] ^ b[31], and FIX runs when neg_pending = 1.
  - Magnitude of 0x80000000 is 0x80000000 treated as unsigned, which is correct.
- Not defined:
  - signed_op is ignored; all operations are unsigned and the FIX state is unreachable.
  - Latency is always 33.

Test Plan:
- Reset release, then a=3, b=5, pulse start -> done after 33 cycles; product_hi=0x00000000, product_lo=0x0000000F; alu_op=5'b00010 throughout.
- a=0xFFFFFFFF, b=0xFFFFFFFF -> product_hi=0xFFFFFFFE, product_lo=0x00000001 (carry path).
- start with a=0x12345678, b=2, then assert start again at cycle 10 with a=1, b=1 -> second start ignored; single done; product = 0x00000000_2468ACF0.
- Reset asserted 10 cycles into RUN -> busy=0 and product=0 immediately; no done pulse; a following 7x6 completes to 42.
- MULT_SIGNED_EN, signed_op=1, a=0xFFFFFFFE (-2), b=3 -> done at cycle 34; product=0xFFFFFFFF_FFFFFFFA. Same operands with signed_op=0 -> 0x00000002_FFFFFFFA at cycle 33.
- a=0, b=0xDEADBEEF -> product 0 after the full 33 cycles; done is one-cycle-wide; busy falls the cycle after done.
